ddr_rd_burst_engine: RTL and testbench
======================================

DDR_RD_BURST_ENGINE -- requirements
Module: ddr_rd_burst_engine

Interface
REQ-001 Parameter C_M_AXI_ADDR_WIDTH, default 32, is the address width of descriptors and AR channel.
REQ-002 Parameter P_MAX_BURST_LEN, default 256, is the maximum beats per AXI burst (legal range 1..256).
REQ-003 i_clk  in  1  single clock; all logic on rising edge.
REQ-004 i_rst  in  1  synchronous, active-high reset.
REQ-005 i_rd_ddr_addr  in  C_M_AXI_ADDR_WIDTH  descriptor start byte address; bits [2:0] ignored (treated 0).
REQ-006 i_rd_ddr_len  in  16  descriptor length in 64-bit beats.
REQ-007 i_rd_ddr_strb  in  8  byte-keep of final beat; 8'h00 treated as 8'hFF.
REQ-008 i_rd_ddr_valid  in  1  descriptor valid (may be a 1-cycle pulse).
REQ-009 o_rd_ddr_ready  out  1  engine can accept a descriptor.
REQ-010 o_rd_ddr_cpl  out  1  1-cycle pulse: descriptor fully delivered.
REQ-011 m_axi_araddr  out  C_M_AXI_ADDR_WIDTH  burst start address.
REQ-012 m_axi_arlen  out  8  beats-1 of current burst.
REQ-013 m_axi_arsize / m_axi_arburst  out  3 / 2  constants 3'b011 / 2'b01 (INCR).
REQ-014 m_axi_arvalid  out  1; m_axi_arready  in  1  AR handshake.
REQ-015 m_axi_rdata  in  64; m_axi_rresp  in  2; m_axi_rlast  in  1  read data beat.
REQ-016 m_axi_rvalid  in  1; m_axi_rready  out  1  R handshake.
REQ-017 m_axis_tdata  out  64; m_axis_tkeep  out  8; m_axis_tlast  out  1  output stream beat.
REQ-018 m_axis_tvalid  out  1; m_axis_tready  in  1  output handshake.
REQ-019 o_rd_err  out  1  sticky error flag.

Function
REQ-020 States IDLE, AR, DATA, DONE; o_rd_ddr_ready SHALL be 1 in IDLE and DONE only.
REQ-021 Accept when i_rd_ddr_valid && o_rd_ddr_ready: latch addr (bits [2:0]=0), len, strb; go to AR if len!=0, else DONE.
REQ-022 Burst beats SHALL be min(remaining, P_MAX_BURST_LEN, (4096-addr[11:0])>>3); bursts never cross a 4 KB boundary.
REQ-023 AR: m_axi_arvalid held 1 with stable araddr/arlen until arready; then DATA.
REQ-024 Exactly one burst outstanding; next AR only after final beat of current burst is forwarded.
REQ-025 DATA: m_axis_tvalid = m_axi_rvalid, m_axi_rready = m_axis_tready, tdata = rdata, combinational pass-through, zero added latency, no beat lost or duplicated under backpressure.
REQ-026 tkeep SHALL be 8'hFF except final beat of descriptor = latched strb; tlast=1 only on final beat of descriptor.
REQ-027 Burst end is set by internal beat counter; rlast asserted on a beat other than the counted last, or absent on it, SHALL set o_rd_err.
REQ-028 Beat with rresp[1]=1 SHALL set o_rd_err; data still forwarded; o_rd_err cleared only by reset.
REQ-029 After burst end: remaining!=0 -> AR with address += beats<<3; remaining==0 -> DONE.
REQ-030 DONE lasts exactly one cycle with o_rd_ddr_cpl=1; a descriptor accepted in DONE is handled as in IDLE; otherwise -> IDLE.
REQ-031 Remaining counter 16 bits, burst counter 9 bits; address arithmetic modulo 2^C_M_AXI_ADDR_WIDTH.

Reset
REQ-032 While i_rst=1: state IDLE; o_rd_ddr_ready, o_rd_ddr_cpl, m_axi_arvalid, m_axi_rready, m_axis_tvalid, m_axis_tlast, o_rd_err = 0; araddr, arlen, tkeep = 0; o_rd_ddr_ready=1 first cycle after release.
REQ-033 Reset mid-operation SHALL abandon the descriptor without o_rd_ddr_cpl; no in-flight R beats are drained.

Verification
REQ-034 addr 0x0000_1000, len 4, strb 0x0F -> one AR arlen=3; 4 beats tkeep FF,FF,FF,0F; tlast on beat 4; cpl pulse cycle after beat 4.
REQ-035 addr 0x0, len 300 -> AR 0x0 arlen=255, then AR 0x800 arlen=43; single tlast on beat 300.
REQ-036 addr 0x0FF0, len 4 -> AR 0x0FF0 arlen=1, then AR 0x1000 arlen=1.
REQ-037 len 8 with m_axis_tready toggling 1/0 each cycle -> rready mirrors tready; 8 beats in order; cpl once.
REQ-038 len 3, rresp=2'b10 on beat 2 -> o_rd_err=1 and stays 1; all 3 beats forwarded; cpl pulse.
REQ-039 i_rst during beat 2 of len 6 -> next cycle all outputs at reset values, no cpl; new descriptor len 1 after release completes normally.

Source files
------------

// File: rtl/ddr_rd_burst_engine_if.sv
// rtl/ddr_rd_burst_engine_if.sv - descriptor, AXI read and output stream bundle for the DDR read burst engine
interface ddr_rd_burst_engine_if #(
  parameter int C_M_AXI_ADDR_WIDTH = 32
);
  logic [C_M_AXI_ADDR_WIDTH-1:0] i_rd_ddr_addr;
  logic [15:0]                   i_rd_ddr_len;
  logic [7:0]                    i_rd_ddr_strb;
  logic                          i_rd_ddr_valid;
  logic                          o_rd_ddr_ready;
  logic                          o_rd_ddr_cpl;
  logic                          o_rd_err;

  logic [C_M_AXI_ADDR_WIDTH-1:0] m_axi_araddr;
  logic [7:0]                    m_axi_arlen;
  logic [2:0]                    m_axi_arsize;
  logic [1:0]                    m_axi_arburst;
  logic                          m_axi_arvalid;
  logic                          m_axi_arready;

  logic [63:0]                   m_axi_rdata;
  logic [1:0]                    m_axi_rresp;
  logic                          m_axi_rlast;
  logic                          m_axi_rvalid;
  logic                          m_axi_rready;

  logic [63:0]                   m_axis_tdata;
  logic [7:0]                    m_axis_tkeep;
  logic                          m_axis_tlast;
  logic                          m_axis_tvalid;
  logic                          m_axis_tready;

  modport master (
    input  i_rd_ddr_addr, i_rd_ddr_len, i_rd_ddr_strb, i_rd_ddr_valid,
    output o_rd_ddr_ready, o_rd_ddr_cpl, o_rd_err,
    output m_axi_araddr, m_axi_arlen, m_axi_arsize, m_axi_arburst, m_axi_arvalid,
    input  m_axi_arready,
    input  m_axi_rdata, m_axi_rresp, m_axi_rlast, m_axi_rvalid,
    output m_axi_rready,
    output m_axis_tdata, m_axis_tkeep, m_axis_tlast, m_axis_tvalid,
    input  m_axis_tready
  );

  modport slave (
    output i_rd_ddr_addr, i_rd_ddr_len, i_rd_ddr_strb, i_rd_ddr_valid,
    input  o_rd_ddr_ready, o_rd_ddr_cpl, o_rd_err,
    input  m_axi_araddr, m_axi_arlen, m_axi_arsize, m_axi_arburst, m_axi_arvalid,
    output m_axi_arready,
    output m_axi_rdata, m_axi_rresp, m_axi_rlast, m_axi_rvalid,
    input  m_axi_rready,
    input  m_axis_tdata, m_axis_tkeep, m_axis_tlast, m_axis_tvalid,
    output m_axis_tready
  );
endinterface

// File: rtl/ddr_rd_burst_engine.sv
// rtl/ddr_rd_burst_engine.sv - splits a read descriptor into 4 KB-safe AXI bursts and streams the beats out
module ddr_rd_burst_engine #(
  parameter int C_M_AXI_ADDR_WIDTH = 32,
  parameter int P_MAX_BURST_LEN    = 256
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  ddr_rd_burst_engine_if.master bus
);
  localparam int AW = C_M_AXI_ADDR_WIDTH;

  typedef enum logic [1:0] {S_IDLE, S_AR, S_DATA, S_DONE} state_t;

  state_t          state;
  logic [15:0]     remaining;
  logic [8:0]      beat_cnt;
  logic [7:0]      strb_q;
  logic            err_q;
  logic            cpl_q;
  logic            arvalid_q;
  logic [AW-1:0]   araddr_q;
  logic [7:0]      arlen_q;

  logic            in_data;
  logic            accept;
  logic            burst_last;
  logic            desc_last;
  logic            beat_hs;
  logic            rlast_err;
  logic [AW-1:0]   acc_addr;
  logic [8:0]      acc_beats;
  logic [8:0]      cur_beats;
  logic [AW-1:0]   next_addr;
  logic [8:0]      next_beats;
  logic            unused_rresp0;

  // Beats that fit before the remaining length, the burst limit or the next 4 KB page runs out.
  function automatic logic [8:0] calc_beats(input logic [11:0] a, input logic [15:0] rem);
    logic [12:0] room;
    logic [15:0] n;
    room = (13'd4096 - {1'b0, a}) >> 3;
    n    = rem;
    if (n > 16'(P_MAX_BURST_LEN)) n = 16'(P_MAX_BURST_LEN);
    if (n > {3'b000, room})       n = {3'b000, room};
    return n[8:0];
  endfunction

  assign in_data    = (state == S_DATA) && !i_rst;
  assign accept     = bus.i_rd_ddr_valid && bus.o_rd_ddr_ready;
  assign burst_last = (beat_cnt == {1'b0, arlen_q});
  assign desc_last  = burst_last && (remaining == 16'd0);
  assign beat_hs    = in_data && bus.m_axi_rvalid && bus.m_axis_tready;
  assign rlast_err  = (bus.m_axi_rlast != burst_last);

  assign acc_addr   = bus.i_rd_ddr_addr & ~AW'(7);
  assign acc_beats  = calc_beats(acc_addr[11:0], bus.i_rd_ddr_len);
  assign cur_beats  = {1'b0, arlen_q} + 9'd1;
  assign next_addr  = araddr_q + (AW'(cur_beats) << 3);
  assign next_beats = calc_beats(next_addr[11:0], remaining);

  assign unused_rresp0 = bus.m_axi_rresp[0];

  assign bus.o_rd_ddr_ready = !i_rst && ((state == S_IDLE) || (state == S_DONE));
  assign bus.o_rd_ddr_cpl   = cpl_q;
  assign bus.o_rd_err       = err_q;
  assign bus.m_axi_araddr   = araddr_q;
  assign bus.m_axi_arlen    = arlen_q;
  assign bus.m_axi_arsize   = 3'b011;
  assign bus.m_axi_arburst  = 2'b01;
  assign bus.m_axi_arvalid  = arvalid_q;

  // Data phase is a pure wire-through so backpressure costs no cycles and no buffering.
  assign bus.m_axi_rready   = in_data && bus.m_axis_tready;
  assign bus.m_axis_tvalid  = in_data && bus.m_axi_rvalid;
  assign bus.m_axis_tdata   = bus.m_axi_rdata;
  assign bus.m_axis_tkeep   = in_data ? (desc_last ? strb_q : 8'hFF) : 8'h00;
  assign bus.m_axis_tlast   = in_data && desc_last;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state     <= S_IDLE;
      remaining <= 16'd0;
      beat_cnt  <= 9'd0;
      strb_q    <= 8'h00;
      err_q     <= 1'b0;
      cpl_q     <= 1'b0;
      arvalid_q <= 1'b0;
      araddr_q  <= '0;
      arlen_q   <= 8'h00;
    end else begin
      cpl_q <= 1'b0;
      case (state)
        S_IDLE, S_DONE: begin
          if (accept) begin
            araddr_q <= acc_addr;
            strb_q   <= (bus.i_rd_ddr_strb == 8'h00) ? 8'hFF : bus.i_rd_ddr_strb;
            beat_cnt <= 9'd0;
            if (bus.i_rd_ddr_len != 16'd0) begin
              arlen_q   <= 8'(acc_beats - 9'd1);
              remaining <= bus.i_rd_ddr_len - 16'(acc_beats);
              arvalid_q <= 1'b1;
              state     <= S_AR;
            end else begin
              remaining <= 16'd0;
              cpl_q     <= 1'b1;
              state     <= S_DONE;
            end
          end else begin
            state <= S_IDLE;
          end
        end
        S_AR: begin
          if (bus.m_axi_arready) begin
            arvalid_q <= 1'b0;
            state     <= S_DATA;
          end
        end
        S_DATA: begin
          if (beat_hs) begin
            if (bus.m_axi_rresp[1] || rlast_err) err_q <= 1'b1;
            if (burst_last) begin
              beat_cnt <= 9'd0;
              if (remaining == 16'd0) begin
                cpl_q <= 1'b1;
                state <= S_DONE;
              end else begin
                araddr_q  <= next_addr;
                arlen_q   <= 8'(next_beats - 9'd1);
                remaining <= remaining - 16'(next_beats);
                arvalid_q <= 1'b1;
                state     <= S_AR;
              end
            end else begin
              beat_cnt <= beat_cnt + 9'd1;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_ddr_rd_burst_engine.sv
// tb/tb_ddr_rd_burst_engine.sv - directed self-checking bench for ddr_rd_burst_engine
module tb_ddr_rd_burst_engine;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   passed = 0;

  always #5 clk = ~clk;

  ddr_rd_burst_engine_if #(.C_M_AXI_ADDR_WIDTH(32)) bus ();

  ddr_rd_burst_engine #(
    .C_M_AXI_ADDR_WIDTH(32),
    .P_MAX_BURST_LEN(256)
  ) dut (
    .i_clk(clk),
    .i_rst(rst),
    .bus  (bus)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  // Waits for an AR request, checks it, stalls arready one cycle, then accepts it.
  task automatic take_ar(input logic [31:0] ea, input logic [7:0] el);
    int waitc;
    waitc = 0;
    while (bus.m_axi_arvalid !== 1'b1 && waitc < 16) begin
      @(negedge clk);
      #1;
      waitc++;
    end
    chk("ar_valid", bus.m_axi_arvalid, 1'b1);
    chk("ar_addr", bus.m_axi_araddr, ea);
    chk("ar_len", bus.m_axi_arlen, el);
    chk("ar_size_burst", {bus.m_axi_arsize, bus.m_axi_arburst}, 5'b011_01);
    @(negedge clk);
    #1;
    chk("ar_hold_valid", bus.m_axi_arvalid, 1'b1);
    chk("ar_hold_addr", bus.m_axi_araddr, ea);
    bus.m_axi_arready = 1'b1;
    @(posedge clk);
  endtask

  task automatic run_desc(input logic [31:0] addr, input logic [15:0] len, input logic [7:0] strb,
                          input int nb, input logic [31:0] a0, input logic [7:0] l0,
                          input logic [31:0] a1, input logic [7:0] l1, input bit toggle,
                          input int err_beat, input int bad_rlast_beat, input logic [7:0] last_keep,
                          input logic exp_err);
    int beat;
    int k;
    int blen;
    int cyc;
    bit tr;
    bit phase;
    logic [63:0] d;
    beat  = 0;
    phase = 1'b1;
    @(negedge clk);
    bus.i_rd_ddr_addr  = addr;
    bus.i_rd_ddr_len   = len;
    bus.i_rd_ddr_strb  = strb;
    bus.i_rd_ddr_valid = 1'b1;
    #1;
    chk("desc_ready", bus.o_rd_ddr_ready, 1'b1);
    @(posedge clk);
    for (int b = 0; b < nb; b++) begin
      @(negedge clk);
      bus.i_rd_ddr_valid = 1'b0;
      bus.m_axi_rvalid   = 1'b0;
      #1;
      take_ar(b == 0 ? a0 : a1, b == 0 ? l0 : l1);
      blen = (b == 0 ? int'(l0) : int'(l1)) + 1;
      k    = 0;
      cyc  = 0;
      while (k < blen && cyc < 2 * blen + 8) begin
        tr    = toggle ? phase : 1'b1;
        phase = ~phase;
        d     = {16'hBEEF, addr[15:0], 32'(beat)};
        @(negedge clk);
        bus.m_axi_arready = 1'b0;
        bus.m_axi_rvalid  = 1'b1;
        bus.m_axi_rdata   = d;
        bus.m_axi_rlast   = (k == blen - 1) ^ (beat == bad_rlast_beat);
        bus.m_axi_rresp   = (beat == err_beat) ? 2'b10 : 2'b00;
        bus.m_axis_tready = tr;
        #1;
        chk("rready_mirror", bus.m_axi_rready, tr);
        chk("tvalid", bus.m_axis_tvalid, 1'b1);
        if (tr) begin
          chk("tdata", bus.m_axis_tdata, d);
          chk("tkeep", bus.m_axis_tkeep, (beat == int'(len) - 1) ? last_keep : 8'hFF);
          chk("tlast", bus.m_axis_tlast, beat == int'(len) - 1);
          k++;
          beat++;
        end
        cyc++;
        @(posedge clk);
      end
      chk("burst_beats", k, blen);
    end
    @(negedge clk);
    bus.i_rd_ddr_valid = 1'b0;
    bus.m_axi_rvalid   = 1'b0;
    bus.m_axi_rlast    = 1'b0;
    bus.m_axi_rresp    = 2'b00;
    bus.m_axis_tready  = 1'b1;
    #1;
    chk("total_beats", beat, int'(len));
    chk("cpl_pulse", bus.o_rd_ddr_cpl, 1'b1);
    chk("done_ready", bus.o_rd_ddr_ready, 1'b1);
    @(negedge clk);
    #1;
    chk("cpl_once", bus.o_rd_ddr_cpl, 1'b0);
    chk("idle_ready", bus.o_rd_ddr_ready, 1'b1);
    chk("err_flag", bus.o_rd_err, exp_err);
  endtask

  initial begin
    bus.i_rd_ddr_addr  = '0;
    bus.i_rd_ddr_len   = '0;
    bus.i_rd_ddr_strb  = '0;
    bus.i_rd_ddr_valid = 1'b0;
    bus.m_axi_arready  = 1'b0;
    bus.m_axi_rdata    = '0;
    bus.m_axi_rresp    = 2'b00;
    bus.m_axi_rlast    = 1'b0;
    bus.m_axi_rvalid   = 1'b1;
    bus.m_axis_tready  = 1'b1;

    repeat (3) @(negedge clk);
    #1;
    chk("rst_ready", bus.o_rd_ddr_ready, 1'b0);
    chk("rst_cpl", bus.o_rd_ddr_cpl, 1'b0);
    chk("rst_arvalid", bus.m_axi_arvalid, 1'b0);
    chk("rst_rready", bus.m_axi_rready, 1'b0);
    chk("rst_tvalid", bus.m_axis_tvalid, 1'b0);
    chk("rst_tlast", bus.m_axis_tlast, 1'b0);
    chk("rst_err", bus.o_rd_err, 1'b0);
    chk("rst_araddr", bus.m_axi_araddr, 32'h0);
    chk("rst_arlen", bus.m_axi_arlen, 8'h0);
    chk("rst_tkeep", bus.m_axis_tkeep, 8'h0);
    @(negedge clk);
    rst = 1'b0;
    bus.m_axi_rvalid = 1'b0;
    #1;
    chk("release_ready", bus.o_rd_ddr_ready, 1'b1);

    // Single burst, partial last keep.
    run_desc(32'h0000_1000, 16'd4, 8'h0F, 1, 32'h0000_1000, 8'd3, 32'h0, 8'd0, 1'b0, -1, -1, 8'h0F, 1'b0);

    // Zero-length descriptor completes without any AR.
    @(negedge clk);
    bus.i_rd_ddr_len   = 16'd0;
    bus.i_rd_ddr_valid = 1'b1;
    @(negedge clk);
    bus.i_rd_ddr_valid = 1'b0;
    #1;
    chk("len0_cpl", bus.o_rd_ddr_cpl, 1'b1);
    chk("len0_no_ar", bus.m_axi_arvalid, 1'b0);
    @(negedge clk);
    #1;
    chk("len0_cpl_once", bus.o_rd_ddr_cpl, 1'b0);

    // Max-length split, 4 KB split with strb 0 -> FF, unaligned start address.
    run_desc(32'h0000_0000, 16'd300, 8'hFF, 2, 32'h0000_0000, 8'd255, 32'h0000_0800, 8'd43, 1'b0, -1, -1, 8'hFF, 1'b0);
    run_desc(32'h0000_0FF0, 16'd4, 8'h00, 2, 32'h0000_0FF0, 8'd1, 32'h0000_1000, 8'd1, 1'b0, -1, -1, 8'hFF, 1'b0);
    run_desc(32'h0000_2005, 16'd1, 8'h03, 1, 32'h0000_2000, 8'd0, 32'h0, 8'd0, 1'b0, -1, -1, 8'h03, 1'b0);

    // Backpressure toggling every cycle.
    run_desc(32'h0000_3000, 16'd8, 8'hFF, 1, 32'h0000_3000, 8'd7, 32'h0, 8'd0, 1'b1, -1, -1, 8'hFF, 1'b0);

    // SLVERR on beat 2 sets the sticky error.
    run_desc(32'h0000_5000, 16'd3, 8'h01, 1, 32'h0000_5000, 8'd2, 32'h0, 8'd0, 1'b0, 1, -1, 8'h01, 1'b1);

    // Reset during beat 2 of a 6-beat descriptor.
    @(negedge clk);
    bus.i_rd_ddr_addr  = 32'h0000_4000;
    bus.i_rd_ddr_len   = 16'd6;
    bus.i_rd_ddr_strb  = 8'hFF;
    bus.i_rd_ddr_valid = 1'b1;
    @(negedge clk);
    bus.i_rd_ddr_valid = 1'b0;
    #1;
    take_ar(32'h0000_4000, 8'd5);
    @(negedge clk);
    bus.m_axi_arready = 1'b0;
    bus.m_axi_rvalid  = 1'b1;
    bus.m_axi_rdata   = 64'h1111_2222_3333_4444;
    bus.m_axis_tready = 1'b1;
    #1;
    chk("mid_beat1_tvalid", bus.m_axis_tvalid, 1'b1);
    chk("err_sticky", bus.o_rd_err, 1'b1);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("mid_rst_tvalid", bus.m_axis_tvalid, 1'b0);
    @(posedge clk);
    @(negedge clk);
    #1;
    chk("mid_rst_ready", bus.o_rd_ddr_ready, 1'b0);
    chk("mid_rst_cpl", bus.o_rd_ddr_cpl, 1'b0);
    chk("mid_rst_arvalid", bus.m_axi_arvalid, 1'b0);
    chk("mid_rst_rready", bus.m_axi_rready, 1'b0);
    chk("mid_rst_tlast", bus.m_axis_tlast, 1'b0);
    chk("mid_rst_err", bus.o_rd_err, 1'b0);
    chk("mid_rst_araddr", bus.m_axi_araddr, 32'h0);
    chk("mid_rst_arlen", bus.m_axi_arlen, 8'h0);
    chk("mid_rst_tkeep", bus.m_axis_tkeep, 8'h0);
    rst = 1'b0;
    bus.m_axi_rvalid = 1'b0;
    #1;
    chk("post_rst_ready", bus.o_rd_ddr_ready, 1'b1);
    chk("post_rst_no_cpl", bus.o_rd_ddr_cpl, 1'b0);
    run_desc(32'h0000_6000, 16'd1, 8'h80, 1, 32'h0000_6000, 8'd0, 32'h0, 8'd0, 1'b0, -1, -1, 8'h80, 1'b0);

    // rlast on the wrong beat flags an error but the burst still ends by count.
    run_desc(32'h0000_7000, 16'd2, 8'hFF, 1, 32'h0000_7000, 8'd1, 32'h0, 8'd0, 1'b0, -1, 0, 8'hFF, 1'b1);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
